cfg_updown_counter: RTL

- Parametrised successor to the team's 4-bit load/hold counter.
- Adds generic width and modulus, up/down direction, and three end-of-range modes (wrap, saturate, one-shot).
- Adds a registered wrap pulse and a sticky done flag.
- Used as the general-purpose timer/sequence counter in control paths; one clock domain.

---
 rtl/cfg_counter_pkg.sv | 10 +
 rtl/cfg_counter_prescaler.sv | 40 ++++
 rtl/cfg_updown_counter.sv | 96 +++++++++
 3 files changed

// File: rtl/cfg_counter_pkg.sv
// Shared mode encoding for the configurable up/down counter.
package cfg_counter_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_WRAP    = 2'b00;
  localparam mode_t MODE_SAT     = 2'b01;
  localparam mode_t MODE_ONESHOT = 2'b10;

endpackage

// File: rtl/cfg_counter_prescaler.sv
// Divides enabled cycles by PRESCALE; tick is high on the enabled cycle that completes a period.
module cfg_counter_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] Last = CntW'(PRESCALE - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == Last) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cfg_updown_counter.sv
// Up/down counter over 0..MAX_VAL with wrap, saturate and one-shot end-of-range modes.
// Define CFG_COUNTER_PRESCALE_EN to advance only once every PRESCALE enabled cycles.
module cfg_updown_counter
  import cfg_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             hold,
  input  logic             up_down,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             at_term,
  output logic             wrap_pulse,
  output logic             done
);

  localparam logic [WIDTH:0] MaxExt = (WIDTH + 1)'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             adv_en;
  logic [WIDTH:0]   count_ext, load_ext, step_ext, term_ext;

`ifdef CFG_COUNTER_PRESCALE_EN
  cfg_counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (load),
    .en   (!hold),
    .tick (adv_en)
  );
`else
  logic unused_prescale;
  assign unused_prescale = (PRESCALE == 0);
  assign adv_en = 1'b1;
`endif

  // Widened by one bit so a non-power-of-two MAX_VAL never aliases on clamp or step.
  assign count_ext = {1'b0, count_q};
  assign load_ext  = {1'b0, load_value};
  assign term_ext  = up_down ? MaxExt : '0;
  assign step_ext  = up_down ? (count_ext + 1'b1) : (count_ext - 1'b1);
  assign at_term   = (count_ext == term_ext);

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    done_d  = done_q;
    if (load) begin
      count_d = (load_ext > MaxExt) ? MaxExt[WIDTH-1:0] : load_value;
      done_d  = 1'b0;
    end else if (!hold && adv_en && !done_q) begin
      if (at_term) begin
        case (mode)
          MODE_SAT:     count_d = count_q;
          MODE_ONESHOT: done_d  = 1'b1;
          default: begin
            count_d = up_down ? '0 : MaxExt[WIDTH-1:0];
            wrap_d  = 1'b1;
          end
        endcase
      end else begin
        count_d = step_ext[WIDTH-1:0];
        if (mode == MODE_ONESHOT && step_ext == term_ext) begin
          done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign count      = count_q;
  assign wrap_pulse = wrap_q;
  assign done       = done_q;

endmodule
